// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor stage per clock.
// Computes {borrow_out, diff} for a - b - borrow_in over a start/busy/done
// handshake. diff and borrow_out are only updated on the edge into DONE.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_next;
    logic             last;

    // One full-subtractor stage on the operand LSBs; the new result bit
    // enters from the MSB side so the LSB-first stream ends up aligned.
    always_comb begin
        d                   = a_sr[0] ^ b_sr[0] ^ br;
        br_next             = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_next            = res >> 1;
        res_next[WIDTH-1]   = d;
        last                = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM, operand/result shift registers and held outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= borrow_in;
                        res   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    res  <= res_next;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        // Result and final borrow are published together.
                        diff       <= res_next;
                        borrow_out <= br_next;
                        state      <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status decode straight from the registered state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances checked every
// cycle against a cycle-count/arithmetic model, plus literal expectations.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic            st [2];
    logic [1:0][7:0] av;
    logic [1:0][7:0] bv;
    logic            biv [2];

    logic       busy8, done8, bo8;
    logic [7:0] diff8;
    logic       busy1, done1, bo1;
    logic [0:0] diff1;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rstn(rstn), .start(st[0]), .a(av[0]), .b(bv[0]),
        .borrow_in(biv[0]), .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rstn(rstn), .start(st[1]), .a(av[1][0:0]), .b(bv[1][0:0]),
        .borrow_in(biv[1]), .busy(busy1), .done(done1), .diff(diff1),
        .borrow_out(bo1)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cycle);
        end
    endtask

    // Model: an accepted request yields a - b - bin exactly WIDTH cycles later,
    // shown for one cycle, then one idle cycle before another start is taken.
    int         rem   [2] = '{0, 0};
    logic       mdone [2] = '{1'b0, 1'b0};
    logic [7:0] mdiff [2] = '{8'h0, 8'h0};
    logic       mbo   [2] = '{1'b0, 1'b0};
    logic [7:0] pend  [2] = '{8'h0, 8'h0};
    logic       pbo   [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        cycle <= cycle + 1;
        for (int k = 0; k < 2; k++) begin
            automatic int         w    = (k == 0) ? 8 : 1;
            automatic logic [7:0] mask = (k == 0) ? 8'hFF : 8'h01;
            automatic int         t;
            if (!rstn) begin
                rem[k] <= 0; mdone[k] <= 1'b0; mdiff[k] <= '0; mbo[k] <= 1'b0;
            end else if (mdone[k]) begin
                mdone[k] <= 1'b0;
            end else if (rem[k] > 0) begin
                rem[k] <= rem[k] - 1;
                if (rem[k] == 1) begin
                    mdone[k] <= 1'b1;
                    mdiff[k] <= pend[k];
                    mbo[k]   <= pbo[k];
                end
            end else if (st[k]) begin
                t = int'(av[k] & mask) - int'(bv[k] & mask) - int'(biv[k]);
                rem[k]  <= w;
                pend[k] <= 8'(t) & mask;
                pbo[k]  <= (t < 0);
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy8", busy8, rem[0] > 0);
            chk("done8", done8, mdone[0]);
            chk("diff8", diff8, mdiff[0]);
            chk("bo8",   bo8,   mbo[0]);
            chk("busy1", busy1, rem[1] > 0);
            chk("done1", done1, mdone[1]);
            chk("diff1", diff1, mdiff[1][0]);
            chk("bo1",   bo1,   mbo[1]);
        end
    end

    task automatic go(input int k, input logic [7:0] a, input logic [7:0] b, input logic bi);
        @(posedge clk); #1;
        st[k] = 1'b1; av[k] = a; bv[k] = b; biv[k] = bi;
        @(posedge clk); #1;
        st[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int cyc);
        cyc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((k == 0) ? done8 : done1) begin
                cyc = cycle;
                break;
            end
        end
        if (cyc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic count_done8(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done8) cnt++;
        end
    endtask

    logic [1:0] tt1 [8] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};

    initial begin
        int c1, c2, nd;
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; av[k] = '0; bv[k] = '0; biv[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_bo",   bo8,   0);
        chk_en = 1'b1;
        #1 rstn = 1'b1;

        // Basic subtract
        go(0, 8'h05, 8'h03, 1'b0);
        wait_done(0, c1);
        chk("basic_diff", diff8, 8'h02);
        chk("basic_bo",   bo8,   0);

        // Underflow cases
        go(0, 8'h00, 8'h01, 1'b0);
        wait_done(0, c1);
        chk("uf1_diff", diff8, 8'hFF);
        chk("uf1_bo",   bo8,   1);
        go(0, 8'hFF, 8'hFF, 1'b1);
        wait_done(0, c1);
        chk("uf2_diff", diff8, 8'hFF);
        chk("uf2_bo",   bo8,   1);

        // Start while busy is dropped
        go(0, 8'h80, 8'h01, 1'b0);
        repeat (2) @(posedge clk); #1;
        st[0] = 1'b1; av[0] = 8'h10; bv[0] = 8'h10;
        @(posedge clk); #1;
        st[0] = 1'b0;
        wait_done(0, c1);
        chk("swb_diff", diff8, 8'h7F);
        chk("swb_bo",   bo8,   0);
        count_done8(15, nd);
        chk("swb_extra_done", nd, 0);

        // Reset mid-operation
        go(0, 8'h55, 8'h22, 1'b0);
        repeat (3) @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rmid_busy", busy8, 0);
        chk("rmid_diff", diff8, 0);
        chk("rmid_bo",   bo8,   0);
        count_done8(12, nd);
        chk("rmid_no_done", nd, 0);
        go(0, 8'h0A, 8'h04, 1'b0);
        wait_done(0, c1);
        chk("rmid_next_diff", diff8, 8'h06);

        // Back-to-back with start held high
        @(posedge clk); #1;
        st[0] = 1'b1; av[0] = 8'h03; bv[0] = 8'h01; biv[0] = 1'b0;
        @(posedge clk); #1;
        av[0] = 8'h01; bv[0] = 8'h03;
        wait_done(0, c1);
        chk("b2b1_diff", diff8, 8'h02);
        chk("b2b1_bo",   bo8,   0);
        repeat (3) @(negedge clk);
        chk("b2b_hold_busy", busy8, 1);
        chk("b2b_hold_diff", diff8, 8'h02);
        wait_done(0, c2);
        st[0] = 1'b0;
        chk("b2b2_diff", diff8, 8'hFE);
        chk("b2b2_bo",   bo8,   1);
        chk("b2b_spacing", c2 - c1, 10);

        // Exhaustive WIDTH=1 truth table, index {a,b,bin} -> {bo,d}
        for (int i = 0; i < 8; i++) begin
            automatic logic [2:0] iv = 3'(i);
            automatic logic [1:0] e  = tt1[i];
            go(1, {7'b0, iv[2]}, {7'b0, iv[1]}, iv[0]);
            wait_done(1, c1);
            chk("w1_diff", diff1, e[0]);
            chk("w1_bo",   bo1,   e[1]);
        end

        // Randomized traffic, including stray starts and rare resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rstn = ($urandom_range(0, 79) != 0);
            for (int k = 0; k < 2; k++) begin
                st[k]  = ($urandom_range(0, 3) == 0);
                av[k]  = 8'($urandom);
                bv[k]  = 8'($urandom);
                biv[k] = 1'($urandom);
            end
        end
        @(posedge clk); #1;
        rstn = 1'b1; st[0] = 1'b0; st[1] = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
